// File: rtl/alu_control_fsm_pkg.sv
// Shared encodings for the ALU control FSM: opcodes, ALU ops, bus sources, states.
package alu_ctrl_pkg;

    // Instruction opcodes, IR[15:13]
    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_ADD = 3'b001;
    localparam logic [2:0] OPC_SUB = 3'b010;
    localparam logic [2:0] OPC_AND = 3'b011;
    localparam logic [2:0] OPC_SHF = 3'b100;
    localparam logic [2:0] OPC_MVI = 3'b101;
    localparam logic [2:0] OPC_CMP = 3'b110;
    localparam logic [2:0] OPC_NOP = 3'b111;

    // ALU operation codes; 000 makes the ALU hold Res
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_BAR = 3'b100;

    // BusW source select
    localparam logic [1:0] BUS_REG  = 2'b00;
    localparam logic [1:0] BUS_IMM  = 2'b01;
    localparam logic [1:0] BUS_G    = 2'b10;
    localparam logic [1:0] BUS_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_MOVE = 2'd0,
        CLS_IMM  = 2'd1,
        CLS_ALU  = 2'd2,
        CLS_NOP  = 2'd3
    } instr_cls_t;

endpackage

// File: rtl/alu_control_fsm_if.sv
// Handshake and datapath-control bundle between the host/datapath and the control FSM.
interface alu_control_fsm_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int SHAMT_W    = 4
) ();
    logic                  Run;
    logic [DATA_W-1:0]     DIN;
    logic                  bitZero;
    logic                  Busy;
    logic                  Done;
    logic [REG_ADDR_W-1:0] regSel;
    logic [1:0]            busSrc;
    logic                  RA_load;
    logic                  G_load;
    logic [2:0]            op;
    logic [SHAMT_W-1:0]    shiftAmt;
    logic                  shiftDir;
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] regWAddr;
    logic                  zeroFlag;

    // Host / datapath side: issues instructions, observes controls
    modport master (
        output Run, DIN, bitZero,
        input  Busy, Done, regSel, busSrc, RA_load, G_load, op,
               shiftAmt, shiftDir, regWrite, regWAddr, zeroFlag
    );

    // Control FSM side
    modport slave (
        input  Run, DIN, bitZero,
        output Busy, Done, regSel, busSrc, RA_load, G_load, op,
               shiftAmt, shiftDir, regWrite, regWAddr, zeroFlag
    );
endinterface

// File: rtl/alu_control_fsm_decoder.sv
// alu_instr_decoder: purely combinational field split and classification of the IR.
module alu_instr_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int SHAMT_W    = 4
) (
    input  logic [DATA_W-1:0]     ir_i,
    output instr_cls_t            cls_o,
    output logic [2:0]            op_o,
    output logic                  writes_back_o,
    output logic                  sets_flag_o,
    output logic                  is_shift_o,
    output logic [SHAMT_W-1:0]    shamt_o,
    output logic                  shdir_o,
    output logic [REG_ADDR_W-1:0] rx_o,
    output logic [REG_ADDR_W-1:0] ry_o
);
    localparam int RX_MSB = DATA_W - 4;
    localparam int RY_MSB = RX_MSB - REG_ADDR_W;
    localparam int GAP_MSB = RY_MSB - REG_ADDR_W;

    logic [2:0] opc;
    logic       unused_imm_hi;

    assign opc     = ir_i[DATA_W-1 -: 3];
    assign rx_o    = ir_i[RX_MSB -: REG_ADDR_W];
    assign ry_o    = ir_i[RY_MSB -: REG_ADDR_W];
    assign shamt_o = ir_i[SHAMT_W-1:0];
    assign shdir_o = ir_i[SHAMT_W];
    // Upper immediate bits only matter to the datapath's immediate path
    assign unused_imm_hi = ^ir_i[GAP_MSB:SHAMT_W+1];

    // Classify opcode and pick the ALU operation; cmp reuses subtract
    always_comb begin
        cls_o         = CLS_ALU;
        op_o          = ALU_NOP;
        writes_back_o = 1'b1;
        is_shift_o    = 1'b0;
        case (opc)
            OPC_MV:  cls_o = CLS_MOVE;
            OPC_MVI: cls_o = CLS_IMM;
            OPC_NOP: begin
                cls_o         = CLS_NOP;
                writes_back_o = 1'b0;
            end
            OPC_ADD: op_o = ALU_ADD;
            OPC_SUB: op_o = ALU_SUB;
            OPC_AND: op_o = ALU_AND;
            OPC_SHF: begin
                op_o       = ALU_BAR;
                is_shift_o = 1'b1;
            end
            OPC_CMP: begin
                op_o          = ALU_SUB;
                writes_back_o = 1'b0;
            end
            default: cls_o = CLS_ALU;
        endcase
        sets_flag_o = (cls_o == CLS_ALU);
    end
endmodule

// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle Moore sequencer for the ALU / barrel-shifter datapath.
module alu_control_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int SHAMT_W    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    alu_control_fsm_if.slave bus
);
    state_t                state_q, state_d;
    logic [DATA_W-1:0]     ir_q, ir_d;
    logic                  zflag_q, zflag_d;

    instr_cls_t            dec_cls;
    logic [2:0]            dec_op;
    logic                  dec_wb;
    logic                  dec_flag;
    logic                  dec_shift;
    logic [SHAMT_W-1:0]    dec_shamt;
    logic                  dec_shdir;
    logic [REG_ADDR_W-1:0] dec_rx;
    logic [REG_ADDR_W-1:0] dec_ry;

    logic                  busy;
    logic                  done;
    logic [REG_ADDR_W-1:0] reg_sel;
    logic [1:0]            bus_src;
    logic                  ra_load;
    logic                  g_load;
    logic [2:0]            alu_op;
    logic [SHAMT_W-1:0]    shift_amt;
    logic                  shift_dir;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] reg_waddr;

    alu_instr_decoder #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .SHAMT_W    (SHAMT_W)
    ) u_dec (
        .ir_i          (ir_q),
        .cls_o         (dec_cls),
        .op_o          (dec_op),
        .writes_back_o (dec_wb),
        .sets_flag_o   (dec_flag),
        .is_shift_o    (dec_shift),
        .shamt_o       (dec_shamt),
        .shdir_o       (dec_shdir),
        .rx_o          (dec_rx),
        .ry_o          (dec_ry)
    );

    // State, instruction and flag registers; reset abandons any instruction in flight
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
        end
    end

    // Next state: Run only matters in IDLE, flag captured when leaving T2
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        zflag_d = zflag_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Run) begin
                    state_d = ST_T1;
                    ir_d    = bus.DIN;
                end
            end
            ST_T1: state_d = (dec_cls == CLS_ALU) ? ST_T2 : ST_IDLE;
            ST_T2: begin
                state_d = ST_T3;
                if (dec_flag) zflag_d = bus.bitZero;
            end
            ST_T3: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and IR only; IDLE drives every control low
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        reg_sel   = '0;
        bus_src   = BUS_REG;
        ra_load   = 1'b0;
        g_load    = 1'b0;
        alu_op    = ALU_NOP;
        reg_write = 1'b0;
        shift_amt = busy ? dec_shamt : '0;
        shift_dir = busy ? dec_shdir : 1'b0;
        reg_waddr = busy ? dec_rx : '0;
        case (state_q)
            ST_T1: begin
                case (dec_cls)
                    CLS_MOVE: begin
                        reg_sel   = dec_ry;
                        reg_write = 1'b1;
                        done      = 1'b1;
                    end
                    CLS_IMM: begin
                        bus_src   = BUS_IMM;
                        reg_write = 1'b1;
                        done      = 1'b1;
                    end
                    CLS_NOP: done = 1'b1;
                    default: begin
                        reg_sel = dec_rx;
                        ra_load = 1'b1;
                    end
                endcase
            end
            ST_T2: begin
                g_load = 1'b1;
                alu_op = dec_op;
                if (dec_shift) bus_src = BUS_NONE;
                else           reg_sel = dec_ry;
            end
            ST_T3: begin
                bus_src   = BUS_G;
                reg_write = dec_wb;
                done      = 1'b1;
            end
            default: done = 1'b0;
        endcase
    end

    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.regSel   = reg_sel;
    assign bus.busSrc   = bus_src;
    assign bus.RA_load  = ra_load;
    assign bus.G_load   = g_load;
    assign bus.op       = alu_op;
    assign bus.shiftAmt = shift_amt;
    assign bus.shiftDir = shift_dir;
    assign bus.regWrite = reg_write;
    assign bus.regWAddr = reg_waddr;
    assign bus.zeroFlag = zflag_q;
endmodule
